// File: rtl/tilexy_mort_arb_pkg.sv
// Shared types and widths for the tile reqmort write-back arbiter.
package tileXY_mort_pkg;

    localparam int ADDR_W = 37;
    localparam int SRC_W  = 3;

    typedef struct packed {
        logic              valid;
        logic [ADDR_W-1:0] addr;
    } sb_entry_t;

    function automatic int tag_w(input int tags);
        return (tags > 1) ? $clog2(tags) : 1;
    endfunction

endpackage

// File: rtl/tilexy_mort_arb_rr_pick.sv
// Rotate-priority picker: first set bit of i_elig at or after i_ptr, wrapping to 0.
module rr_pick
    import tileXY_mort_pkg::*;
#(
    parameter int N = 6
) (
    input  logic [N-1:0]     i_elig,
    input  logic [SRC_W-1:0] i_ptr,
    output logic [N-1:0]     o_onehot,
    output logic [SRC_W-1:0] o_idx,
    output logic             o_any
);

    // First pass covers ptr..N-1, second pass picks up the wrapped part 0..ptr-1.
    always_comb begin
        o_onehot = '0;
        o_idx    = '0;
        o_any    = 1'b0;
        for (int i = 0; i < N; i++) begin
            if (!o_any && i_elig[i] && (i >= int'(i_ptr))) begin
                o_any       = 1'b1;
                o_onehot[i] = 1'b1;
                o_idx       = SRC_W'(i);
            end
        end
        for (int i = 0; i < N; i++) begin
            if (!o_any && i_elig[i]) begin
                o_any       = 1'b1;
                o_onehot[i] = 1'b1;
                o_idx       = SRC_W'(i);
            end
        end
    end

endmodule

// File: rtl/tilexy_mort_arb.sv
// Round-robin arbiter for the tile reqmort port with expunge priority,
// a tag scoreboard of in-flight lines and same-address blocking.
module tilexy_mort_arb
    import tileXY_mort_pkg::*;
#(
    parameter int NREQ = 6,
    parameter int TAGS = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [NREQ-1:0]        req_en,
    input  logic [NREQ*ADDR_W-1:0] req_addr,
    input  logic [NREQ-1:0]        req_expun,
    output logic [NREQ-1:0]        req_gnt,
    output logic                   mort_en,
    output logic [ADDR_W-1:0]      mort_addr,
    output logic                   mort_expun,
    output logic [SRC_W-1:0]       mort_src,
    output logic [tag_w(TAGS)-1:0] mort_tag,
    input  logic                   mort_rdy,
    input  logic                   done_en,
    input  logic [tag_w(TAGS)-1:0] done_tag,
    output logic                   busy
);

    localparam int TAG_W = tag_w(TAGS);

    sb_entry_t         r_sb [TAGS];
    logic [SRC_W-1:0]  r_rr;
    logic              r_mort_en;
    logic [ADDR_W-1:0] r_mort_addr;
    logic              r_mort_expun;
    logic [SRC_W-1:0]  r_mort_src;
    logic [TAG_W-1:0]  r_mort_tag;
    logic              r_busy;

    logic [TAGS-1:0]   w_valid;
    logic [TAGS-1:0]   w_valid_nxt;
    logic [NREQ-1:0]   w_hit;
    logic [NREQ-1:0]   w_elig;
    logic [NREQ-1:0]   w_elig_ex;
    logic [NREQ-1:0]   w_gnt_all;
    logic [NREQ-1:0]   w_gnt_ex;
    logic [NREQ-1:0]   w_win;
    logic [SRC_W-1:0]  w_idx_all;
    logic [SRC_W-1:0]  w_idx_ex;
    logic [SRC_W-1:0]  w_idx;
    logic              w_any_all;
    logic              w_any_ex;
    logic              w_full;
    logic              w_slot_free;
    logic              w_grant;
    logic [TAG_W-1:0]  w_free_tag;
    logic [ADDR_W-1:0] w_gaddr;
    logic              w_gexpun;

    always_comb begin
        w_valid = '0;
        for (int t = 0; t < TAGS; t++) w_valid[t] = r_sb[t].valid;
    end

    // An entry that completes this cycle still blocks its address until the edge.
    always_comb begin
        w_hit = '0;
        for (int i = 0; i < NREQ; i++)
            for (int t = 0; t < TAGS; t++)
                if (r_sb[t].valid && (r_sb[t].addr == req_addr[i*ADDR_W +: ADDR_W]))
                    w_hit[i] = 1'b1;
    end

    assign w_full      = &w_valid;
    assign w_elig      = req_en & ~w_hit & {NREQ{~w_full}};
    assign w_elig_ex   = w_elig & req_expun;
    assign w_slot_free = !r_mort_en || mort_rdy;

    rr_pick #(.N(NREQ)) u_pick_ex (
        .i_elig   (w_elig_ex),
        .i_ptr    (r_rr),
        .o_onehot (w_gnt_ex),
        .o_idx    (w_idx_ex),
        .o_any    (w_any_ex)
    );

    rr_pick #(.N(NREQ)) u_pick_all (
        .i_elig   (w_elig),
        .i_ptr    (r_rr),
        .o_onehot (w_gnt_all),
        .o_idx    (w_idx_all),
        .o_any    (w_any_all)
    );

    assign w_win   = w_any_ex ? w_gnt_ex : w_gnt_all;
    assign w_idx   = w_any_ex ? w_idx_ex : w_idx_all;
    assign w_grant = rst && w_slot_free && w_any_all;
    assign req_gnt = w_grant ? w_win : '0;

    // Allocation looks only at registered valids, so a tag freed this cycle is never reused now.
    always_comb begin
        w_free_tag = '0;
        for (int t = TAGS - 1; t >= 0; t--)
            if (!w_valid[t]) w_free_tag = TAG_W'(t);
    end

    always_comb begin
        w_gaddr = '0;
        for (int i = 0; i < NREQ; i++)
            if (w_win[i]) w_gaddr = req_addr[i*ADDR_W +: ADDR_W];
    end

    assign w_gexpun = |(w_win & req_expun);

    always_comb begin
        w_valid_nxt = w_valid;
        if (done_en) w_valid_nxt[done_tag] = 1'b0;
        if (w_grant) w_valid_nxt[w_free_tag] = 1'b1;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int t = 0; t < TAGS; t++) r_sb[t] <= '0;
            r_rr         <= '0;
            r_mort_en    <= 1'b0;
            r_mort_addr  <= '0;
            r_mort_expun <= 1'b0;
            r_mort_src   <= '0;
            r_mort_tag   <= '0;
            r_busy       <= 1'b0;
        end else begin
            for (int t = 0; t < TAGS; t++) r_sb[t].valid <= w_valid_nxt[t];
            r_busy <= |w_valid_nxt;
            if (w_grant) begin
                r_sb[w_free_tag].addr <= w_gaddr;
                r_rr         <= (w_idx == SRC_W'(NREQ - 1)) ? '0 : w_idx + 1'b1;
                r_mort_en    <= 1'b1;
                r_mort_addr  <= w_gaddr;
                r_mort_expun <= w_gexpun;
                r_mort_src   <= w_idx;
                r_mort_tag   <= w_free_tag;
            end else if (mort_rdy) begin
                r_mort_en    <= 1'b0;
            end
        end
    end

    assign mort_en    = r_mort_en;
    assign mort_addr  = r_mort_addr;
    assign mort_expun = r_mort_expun;
    assign mort_src   = r_mort_src;
    assign mort_tag   = r_mort_tag;
    assign busy       = r_busy;

endmodule

// File: tb/tb_tilexy_mort_arb.sv
// Self-checking bench for tilexy_mort_arb: per-cycle model comparison plus directed literal checks.
module tb_tilexy_mort_arb;
    import tileXY_mort_pkg::*;

    localparam int NREQ = 6;
    localparam int TAGS = 4;
    localparam int TW   = 2;

    logic                   clk;
    logic                   rst;
    logic [NREQ-1:0]        req_en;
    logic [NREQ*ADDR_W-1:0] req_addr;
    logic [NREQ-1:0]        req_expun;
    logic [NREQ-1:0]        req_gnt;
    logic                   mort_en;
    logic [ADDR_W-1:0]      mort_addr;
    logic                   mort_expun;
    logic [SRC_W-1:0]       mort_src;
    logic [TW-1:0]          mort_tag;
    logic                   mort_rdy;
    logic                   done_en;
    logic [TW-1:0]          done_tag;
    logic                   busy;

    logic [ADDR_W-1:0] a_src [NREQ];
    bit                auto_done;

    int errors = 0;
    int checks = 0;

    // Model state: what the registered outputs and scoreboard must hold after each edge.
    bit                m_valid [TAGS];
    logic [ADDR_W-1:0] m_addr  [TAGS];
    int                m_rr;
    bit                m_en;
    logic [ADDR_W-1:0] m_oaddr;
    bit                m_exp;
    int                m_src;
    int                m_tag;
    bit                m_busy;
    int                m_last_win;
    int                log_src [$];
    int                log_tag [$];

    tilexy_mort_arb #(.NREQ(NREQ), .TAGS(TAGS)) dut (
        .clk        (clk),
        .rst        (rst),
        .req_en     (req_en),
        .req_addr   (req_addr),
        .req_expun  (req_expun),
        .req_gnt    (req_gnt),
        .mort_en    (mort_en),
        .mort_addr  (mort_addr),
        .mort_expun (mort_expun),
        .mort_src   (mort_src),
        .mort_tag   (mort_tag),
        .mort_rdy   (mort_rdy),
        .done_en    (done_en),
        .done_tag   (done_tag),
        .busy       (busy)
    );

    always_comb begin
        req_addr = '0;
        for (int i = 0; i < NREQ; i++) req_addr[i*ADDR_W +: ADDR_W] = a_src[i];
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        for (int t = 0; t < TAGS; t++) begin
            m_valid[t] = 1'b0;
            m_addr[t]  = '0;
        end
        m_rr = 0; m_en = 1'b0; m_oaddr = '0; m_exp = 1'b0;
        m_src = 0; m_tag = 0; m_busy = 1'b0; m_last_win = -1;
    endtask

    always @(negedge clk) begin : cmp
        int win, nv, ft, idx;
        bit full, anyex, hit;
        logic [NREQ-1:0] elig, eg;
        if (!rst) begin
            model_reset();
            check("rst_gnt",   64'(req_gnt),    64'(0));
            check("rst_en",    64'(mort_en),    64'(0));
            check("rst_addr",  64'(mort_addr),  64'(0));
            check("rst_expun", 64'(mort_expun), 64'(0));
            check("rst_src",   64'(mort_src),   64'(0));
            check("rst_tag",   64'(mort_tag),   64'(0));
            check("rst_busy",  64'(busy),       64'(0));
        end else begin
            check("mort_en",    64'(mort_en),    64'(m_en));
            check("mort_addr",  64'(mort_addr),  64'(m_oaddr));
            check("mort_expun", 64'(mort_expun), 64'(m_exp));
            check("mort_src",   64'(mort_src),   64'(m_src));
            check("mort_tag",   64'(mort_tag),   64'(m_tag));
            check("busy",       64'(busy),       64'(m_busy));
            nv = 0;
            for (int t = 0; t < TAGS; t++) if (m_valid[t]) nv++;
            full  = (nv == TAGS);
            anyex = 1'b0;
            elig  = '0;
            for (int i = 0; i < NREQ; i++) begin
                hit = 1'b0;
                for (int t = 0; t < TAGS; t++)
                    if (m_valid[t] && m_addr[t] == a_src[i]) hit = 1'b1;
                elig[i] = req_en[i] && !full && !hit;
                if (elig[i] && req_expun[i]) anyex = 1'b1;
            end
            win = -1;
            if (!m_en || mort_rdy) begin
                for (int k = 0; k < NREQ; k++) begin
                    idx = (m_rr + k) % NREQ;
                    if (win < 0 && elig[idx] && (!anyex || req_expun[idx])) win = idx;
                end
            end
            eg = '0;
            if (win >= 0) eg = NREQ'(1) << win;
            check("req_gnt", 64'(req_gnt), 64'(eg));
            ft = -1;
            for (int t = TAGS - 1; t >= 0; t--) if (!m_valid[t]) ft = t;
            if (done_en && m_valid[done_tag]) m_valid[done_tag] = 1'b0;
            if (win >= 0) begin
                m_valid[ft] = 1'b1;
                m_addr[ft]  = a_src[win];
                m_en        = 1'b1;
                m_oaddr     = a_src[win];
                m_exp       = req_expun[win];
                m_src       = win;
                m_tag       = ft;
                m_rr        = (win + 1) % NREQ;
                log_src.push_back(win);
                log_tag.push_back(ft);
            end else if (mort_rdy) begin
                m_en = 1'b0;
            end
            m_busy = 1'b0;
            for (int t = 0; t < TAGS; t++) if (m_valid[t]) m_busy = 1'b1;
            m_last_win = win;
        end
    end

    task automatic step(input bit clr);
        @(posedge clk); #1;
        if (clr && m_last_win >= 0) req_en[m_last_win] = 1'b0;
        if (auto_done) begin
            done_en  = m_en;
            done_tag = TW'(m_tag);
        end
    endtask

    task automatic do_reset();
        rst = 1'b0; req_en = '0; req_expun = '0; mort_rdy = 1'b0;
        done_en = 1'b0; done_tag = '0; auto_done = 1'b0;
        for (int i = 0; i < NREQ; i++) a_src[i] = '0;
        step(1'b0);
        step(1'b0);
        log_src.delete();
        log_tag.delete();
        rst = 1'b1;
    endtask

    task automatic sample();
        @(negedge clk); #1;
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation time exceeded 200000 without finishing");
        $fatal(1);
    end

    initial begin
        int exp_rr [6];
        rst = 1'b0; req_en = '0; req_expun = '0; mort_rdy = 1'b0;
        done_en = 1'b0; done_tag = '0; auto_done = 1'b0;
        for (int i = 0; i < NREQ; i++) a_src[i] = '0;
        model_reset();

        // Reset then a single request from source 2
        do_reset();
        check("t1_rst_busy", 64'(busy), 64'(0));
        mort_rdy = 1'b1;
        a_src[2] = 37'h0_0000_1230;
        req_en[2] = 1'b1;
        sample();
        check("t1_gnt", 64'(req_gnt), 64'(6'b000100));
        step(1'b1);
        sample();
        check("t1_en",   64'(mort_en),   64'(1));
        check("t1_src",  64'(mort_src),  64'(2));
        check("t1_tag",  64'(mort_tag),  64'(0));
        check("t1_addr", 64'(mort_addr), 64'(37'h1230));
        check("t1_busy", 64'(busy),      64'(1));

        // Round-robin among 0,1,3 with immediate completion
        do_reset();
        mort_rdy = 1'b1; auto_done = 1'b1;
        a_src[0] = 37'h100; a_src[1] = 37'h200; a_src[3] = 37'h300;
        req_en = 6'b001011;
        for (int c = 0; c < 6; c++) step(1'b0);
        req_en = '0;
        for (int c = 0; c < 3; c++) step(1'b0);
        exp_rr = '{0, 1, 3, 0, 1, 3};
        check("t2_count", 64'(log_src.size()), 64'(6));
        for (int k = 0; k < 6; k++)
            if (k < log_src.size()) check("t2_order", 64'(log_src[k]), 64'(exp_rr[k]));

        // Expunge priority
        do_reset();
        mort_rdy = 1'b1;
        a_src[0] = 37'h500; a_src[4] = 37'h600;
        req_expun[4] = 1'b1;
        req_en = 6'b010001;
        sample();
        check("t3_first_gnt", 64'(req_gnt), 64'(6'b010000));
        for (int c = 0; c < 3; c++) step(1'b1);
        check("t3_count", 64'(log_src.size()), 64'(2));
        if (log_src.size() >= 2) begin
            check("t3_first",  64'(log_src[0]), 64'(4));
            check("t3_second", 64'(log_src[1]), 64'(0));
        end

        // Address conflict between sources 1 and 5
        do_reset();
        mort_rdy = 1'b1;
        a_src[1] = 37'h40;
        req_en[1] = 1'b1;
        step(1'b1);
        a_src[5] = 37'h40;
        req_en[5] = 1'b1;
        for (int c = 0; c < 3; c++) begin
            sample();
            check("t4_blocked", 64'(req_gnt), 64'(0));
            step(1'b1);
        end
        done_en = 1'b1; done_tag = 2'd0;
        sample();
        check("t4_same_cycle", 64'(req_gnt), 64'(0));
        step(1'b1);
        done_en = 1'b0;
        sample();
        check("t4_gnt", 64'(req_gnt), 64'(6'b100000));
        step(1'b1);
        sample();
        check("t4_src", 64'(mort_src), 64'(5));
        check("t4_tag", 64'(mort_tag), 64'(0));

        // Scoreboard full with backpressure on the fourth output
        do_reset();
        mort_rdy = 1'b1;
        for (int i = 0; i < 4; i++) a_src[i] = 37'h1000 + 37'(i * 16);
        req_en = 6'b001111;
        for (int c = 0; c < 4; c++) step(1'b1);
        mort_rdy = 1'b0;
        a_src[4] = 37'h2000;
        req_en[4] = 1'b1;
        for (int c = 0; c < 3; c++) begin
            sample();
            check("t5_full_gnt", 64'(req_gnt),   64'(0));
            check("t5_hold_en",  64'(mort_en),   64'(1));
            check("t5_hold_src", 64'(mort_src),  64'(3));
            check("t5_hold_tag", 64'(mort_tag),  64'(3));
            check("t5_hold_adr", 64'(mort_addr), 64'(37'h1030));
            step(1'b1);
        end
        mort_rdy = 1'b1;
        done_en = 1'b1; done_tag = 2'd2;
        sample();
        check("t5_done_cycle", 64'(req_gnt), 64'(0));
        step(1'b1);
        done_en = 1'b0;
        sample();
        check("t5_gnt", 64'(req_gnt), 64'(6'b010000));
        step(1'b1);
        sample();
        check("t5_tag", 64'(mort_tag), 64'(2));
        check("t5_src", 64'(mort_src), 64'(4));

        // Spurious completion, then reset with three tags in flight
        do_reset();
        mort_rdy = 1'b1;
        for (int i = 0; i < 3; i++) a_src[i] = 37'h3000 + 37'(i * 16);
        req_en = 6'b000111;
        for (int c = 0; c < 3; c++) step(1'b1);
        done_en = 1'b1; done_tag = 2'd3;
        sample();
        check("t6_busy_a", 64'(busy), 64'(1));
        step(1'b1);
        done_en = 1'b0;
        sample();
        check("t6_busy_b", 64'(busy), 64'(1));
        step(1'b1);
        rst = 1'b0;
        #2;
        check("t6_rst_busy", 64'(busy),    64'(0));
        check("t6_rst_en",   64'(mort_en), 64'(0));
        step(1'b1);
        step(1'b1);
        rst = 1'b1;
        a_src[3] = 37'h3000; a_src[5] = 37'h5000;
        req_en = 6'b101000;
        sample();
        check("t6_gnt", 64'(req_gnt), 64'(6'b001000));
        step(1'b1);
        sample();
        check("t6_tag", 64'(mort_tag), 64'(0));
        check("t6_src", 64'(mort_src), 64'(3));
        step(1'b1);
        step(1'b1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/tilexy_mort_arb.md
# tileXY_mort_arb

Arbitration and sequencing controller for the tile's shared reqmort write-back port. Up to NREQ per-tile cluster FIFO sources raise line write-back/expunge requests; the block grants one per cycle round-robin, with expunges taking priority. It tracks each outgoing request in a tag scoreboard until the memory side reports completion, and blocks any new request whose line address is already in flight. It sits between the tileXY cluster FIFOs' reqmort outputs and the tile memory port.

## Interface
Parameters:
- NREQ, 6, number of requesting sources (2..8).
- TAGS, 4, scoreboard depth and maximum outstanding requests (power of 2, 2..8).

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  asynchronous, active-low reset (0 = reset).
- req_en  in  NREQ  per-source request; held high with stable payload until granted.
- req_addr  in  NREQ×37  per-source line address [36:0].
- req_expun  in  NREQ  per-source expunge flag.
- req_gnt  out  NREQ  one-hot grant pulse, combinational, same cycle as acceptance.
- mort_en  out  1  output request valid (registered).
- mort_addr  out  37  granted address.
- mort_expun  out  1  granted expunge flag.
- mort_src  out  3  granted source index.
- mort_tag  out  log2(TAGS)  allocated scoreboard tag.
- mort_rdy  in  1  downstream accepts when mort_en && mort_rdy.
- done_en  in  1  completion strobe.
- done_tag  in  log2(TAGS)  tag being completed.
- busy  out  1  any scoreboard entry valid (registered).

## Operation
- Eligibility of source i: req_en[i], scoreboard not full, and req_addr[i] ≠ address of every valid scoreboard entry. A full 37-bit compare is used.
- Selection:
  - If any eligible source has req_expun, round-robin among eligible expunge sources only.
  - Otherwise, round-robin among all eligible sources.
  - The search starts at pointer rr. After a grant to source w, rr ← (w+1) mod NREQ. rr is unchanged when nothing is granted.
- Grant is issued only when the output slot is free: !mort_en, or mort_en && mort_rdy in the same cycle.
- On grant:
  - Allocate the lowest-numbered free tag and set its entry valid with the address.
  - Load the output register {addr, expun, src, tag}.
  - Set mort_en next cycle.
- Output register holds all fields stable while mort_en && !mort_rdy.
- Completion (done_en):
  - Clears the entry for done_tag at the clock edge.
  - Completion of a tag that is not valid is ignored, with no other side effect.
- A tag stays allocated from grant until completion, including while it sits in the output register.

## Timing
- Reset: req_gnt=0; mort_en=0; mort_addr=0; mort_expun=0; mort_src=0; mort_tag=0; busy=0. The scoreboard is emptied and rr=0. Reset asserted mid-operation discards all in-flight state immediately; no completion is expected afterwards.
- Grant-to-output latency: 1 cycle (req_gnt at T, mort_en at T+1). Sustained throughput is 1 grant/cycle while mort_rdy=1 and tags are free.
- A freed tag is usable at T+1 after done_en at T. Same-cycle done and allocate never reuse the tag being freed. The address compare at T still sees the completing entry, so a same-address request waits until T+1.
- Full (TAGS valid): no grant. Requests are held by their sources.
- Two same-address requests from different sources: the first is granted; the second is blocked until the first's tag completes.
- rr wraps NREQ-1 → 0.
- busy: registered, equal to OR of entry valids.

## Structure
- Package tileXY_mort_pkg: address width 37, source-index width 3, the scoreboard entry typedef {valid, addr[36:0]}, and the tag width function.
- Sub-module rr_pick #(N): combinational rotate-priority pick. Inputs are an eligible vector and a pointer; outputs are a one-hot winner and its index. The block instantiates it twice (expunge-only vector, all-eligible vector) and muxes on "any expunge eligible".
- The scoreboard, tag allocator and output register are local to the block.

## Test plan
- Reset and single request:
  - Stimulus: rst low, then high; req_en[2]=1, addr=0x0_0000_1230, mort_rdy=1.
  - Required: req_gnt=0b000100 at T. At T+1, mort_en=1, mort_src=2, mort_tag=0. busy=1 from T+1.
- Round-robin:
  - Stimulus: sources 0, 1 and 3 requesting continuously with distinct addresses; done returned immediately.
  - Required: grant order 0, 1, 3, 0, 1, 3.
- Expunge priority:
  - Stimulus: sources 0 and 4 request, source 4 with req_expun=1; rr=0.
  - Required: source 4 granted first, then source 0.
- Address conflict:
  - Stimulus: source 1 granted addr 0x40 (tag 0); source 5 requests addr 0x40.
  - Required: source 5 gets no grant until done_en with done_tag=0 at T, then is granted at T+1 with tag 0.
- Full and backpressure:
  - Stimulus: TAGS=4, four grants with no done; mort_rdy=0 on the fourth.
  - Required: the fifth request is not granted; the fourth output stays stable; after mort_rdy=1 and done_tag=2, the next grant receives tag 2.
- Spurious done and reset mid-flight:
  - Stimulus: done_en on an unallocated tag; then rst pulsed low with 3 tags valid.
  - Required: the spurious done causes no state change; after reset, busy=0, mort_en=0, and the next grant receives tag 0 from rr=0.
